// File: rtl/rx_ts_lane_qualifier.sv
// Per-lane training-set qualifier: counts consecutive matching TS per lane
// and ends a run on success, empty mask or (with RX_TS_QUAL_TIMEOUT_EN) timeout.
module rx_ts_lane_qualifier #(
    parameter int LANES     = 16,
    parameter int CNT_WIDTH = 5,
    parameter int TO_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LANES-1:0]     lane_mask,
    input  logic [CNT_WIDTH-1:0] threshold,
    input  logic [1:0]           mode,
    input  logic [TO_WIDTH-1:0]  timeout_cycles,
    input  logic [LANES-1:0]     os_valid,
    input  logic [LANES-1:0]     os_match,
    input  logic [8*LANES-1:0]   os_link_num,
    input  logic [8*LANES-1:0]   os_rate_id,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           result,
    output logic [LANES-1:0]     qualified_lanes,
    output logic [7:0]           link_num_out,
    output logic [7:0]           rate_id_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LANES-1:0]                r_mask;
    logic [CNT_WIDTH-1:0]            r_thr;
    logic [1:0]                      r_mode;
    logic [LANES-1:0][CNT_WIDTH-1:0] r_cnt;
    logic [LANES-1:0][7:0]           r_link;
    logic [LANES-1:0][7:0]           r_rate;
    logic [LANES-1:0]                r_qual;
    logic [1:0]                      r_result;
    logic [7:0]                      r_link_out;
    logic [7:0]                      r_rate_out;

    logic [LANES-1:0][CNT_WIDTH-1:0] w_cnt_nxt;
    logic [LANES-1:0][7:0]           w_link_nxt;
    logic [LANES-1:0][7:0]           w_rate_nxt;
    logic [LANES-1:0]                w_qual_nxt;
    logic [5:0]                      w_nq;
    logic [5:0]                      w_nm;
    logic                            w_success;
    logic                            w_timeout;
    logic                            w_fin;
    logic [1:0]                      w_code;
    logic [7:0]                      w_lo_link;
    logic [7:0]                      w_lo_rate;

`ifdef RX_TS_QUAL_TIMEOUT_EN
    logic [TO_WIDTH-1:0] r_to;
    logic [TO_WIDTH-1:0] r_timer;
    logic [TO_WIDTH-1:0] w_to_last;

    assign w_to_last = r_to - TO_WIDTH'(1);
    assign w_timeout = (r_timer == w_to_last);

    // Run-length timer, restarted by every start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to    <= '0;
            r_timer <= '0;
        end else if (start) begin
            r_to    <= timeout_cycles;
            r_timer <= '0;
        end else if (r_state == S_RUN) begin
            r_timer <= r_timer + TO_WIDTH'(1);
        end
    end
`else
    logic w_unused_to;
    assign w_unused_to = ^timeout_cycles;
    assign w_timeout   = 1'b0;
`endif

    // Per-lane counter, stored link/rate pair and sticky flag update
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_link_nxt = r_link;
        w_rate_nxt = r_rate;
        w_qual_nxt = r_qual;
        for (int i = 0; i < LANES; i++) begin
            if (r_mask[i] && os_valid[i]) begin
                if (!os_match[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (os_link_num[8*i +: 8] == r_link[i] &&
                             os_rate_id[8*i +: 8] == r_rate[i]) begin
                    if (r_cnt[i] < r_thr)
                        w_cnt_nxt[i] = r_cnt[i] + CNT_WIDTH'(1);
                end else begin
                    w_cnt_nxt[i]  = CNT_WIDTH'(1);
                    w_link_nxt[i] = os_link_num[8*i +: 8];
                    w_rate_nxt[i] = os_rate_id[8*i +: 8];
                end
            end
            if (r_mask[i] && w_cnt_nxt[i] >= r_thr)
                w_qual_nxt[i] = 1'b1;
        end
    end

    // Success decision on the registered flags, plus lowest qualified lane
    always_comb begin
        w_nq      = '0;
        w_nm      = '0;
        w_lo_link = '0;
        w_lo_rate = '0;
        for (int i = 0; i < LANES; i++) begin
            w_nq = w_nq + 6'(r_qual[i]);
            w_nm = w_nm + 6'(r_mask[i]);
        end
        for (int i = LANES - 1; i >= 0; i--) begin
            if (r_qual[i]) begin
                w_lo_link = r_link[i];
                w_lo_rate = r_rate[i];
            end
        end
        case (r_mode)
            2'd1:    w_success = |r_qual;
            2'd2:    w_success = {w_nq, 1'b0} > {1'b0, w_nm};
            default: w_success = ((r_qual & r_mask) == r_mask);
        endcase
    end

    // Run controller: next state and end-of-run code
    always_comb begin
        w_next = r_state;
        w_fin  = 1'b0;
        w_code = 2'b00;
        case (r_state)
            S_RUN: begin
                if (r_mask == '0) begin
                    w_fin  = 1'b1;
                    w_code = 2'b11;
                end else if (w_success) begin
                    w_fin  = 1'b1;
                    w_code = 2'b01;
                end else if (w_timeout) begin
                    w_fin  = 1'b1;
                    w_code = 2'b10;
                end
                if (w_fin)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (start)
            w_next = S_RUN;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Config sampling, lane state and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask     <= '0;
            r_thr      <= '0;
            r_mode     <= '0;
            r_cnt      <= '0;
            r_link     <= '0;
            r_rate     <= '0;
            r_qual     <= '0;
            r_result   <= '0;
            r_link_out <= '0;
            r_rate_out <= '0;
        end else if (start) begin
            r_mask     <= lane_mask;
            r_thr      <= (threshold == '0) ? CNT_WIDTH'(1) : threshold;
            r_mode     <= mode;
            r_cnt      <= '0;
            r_link     <= '0;
            r_rate     <= '0;
            r_qual     <= '0;
            r_result   <= '0;
            r_link_out <= '0;
            r_rate_out <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt  <= w_cnt_nxt;
            r_link <= w_link_nxt;
            r_rate <= w_rate_nxt;
            r_qual <= w_qual_nxt;
            if (w_fin) begin
                r_result   <= w_code;
                r_link_out <= w_lo_link;
                r_rate_out <= w_lo_rate;
            end
        end
    end

    assign busy            = (r_state == S_RUN);
    assign done            = (r_state == S_DONE);
    assign result          = r_result;
    assign qualified_lanes = r_qual;
    assign link_num_out    = r_link_out;
    assign rate_id_out     = r_rate_out;

endmodule

// File: tb/tb_rx_ts_lane_qualifier.sv
// Directed bench for rx_ts_lane_qualifier with a scoreboard of expected
// run outcomes popped on each done pulse.
module tb_rx_ts_lane_qualifier;

    typedef struct {
        logic [1:0]  res;
        logic [15:0] qual;
        logic [7:0]  link;
        logic [7:0]  rate;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [15:0]  lane_mask;
    logic [4:0]   threshold;
    logic [1:0]   mode;
    logic [23:0]  timeout_cycles;
    logic [15:0]  os_valid;
    logic [15:0]  os_match;
    logic [127:0] os_link_num;
    logic [127:0] os_rate_id;
    logic         busy;
    logic         done;
    logic [1:0]   result;
    logic [15:0]  qualified_lanes;
    logic [7:0]   link_num_out;
    logic [7:0]   rate_id_out;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   done_seen;
    int   d0;

    rx_ts_lane_qualifier dut (
        .clk             (clk),
        .reset           (rst_n),
        .start           (start),
        .lane_mask       (lane_mask),
        .threshold       (threshold),
        .mode            (mode),
        .timeout_cycles  (timeout_cycles),
        .os_valid        (os_valid),
        .os_match        (os_match),
        .os_link_num     (os_link_num),
        .os_rate_id      (os_rate_id),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .qualified_lanes (qualified_lanes),
        .link_num_out    (link_num_out),
        .rate_id_out     (rate_id_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_run(input logic [1:0] r, input logic [15:0] q,
                              input logic [7:0] l, input logic [7:0] t);
        exp_t e;
        e.res  = r;
        e.qual = q;
        e.link = l;
        e.rate = t;
        exp_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (done) begin
            done_seen++;
            chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_result", 32'(result), 32'(e.res));
                chk("sb_qual", 32'(qualified_lanes), 32'(e.qual));
                chk("sb_link", 32'(link_num_out), 32'(e.link));
                chk("sb_rate", 32'(rate_id_out), 32'(e.rate));
                chk("sb_busy", 32'(busy), 0);
            end
        end
    endtask

    task automatic start_run(input logic [15:0] m, input logic [4:0] th,
                             input logic [1:0] md, input logic [23:0] to);
        start          = 1'b1;
        lane_mask      = m;
        threshold      = th;
        mode           = md;
        timeout_cycles = to;
        step();
        start          = 1'b0;
        lane_mask      = 16'hFFFF;
        threshold      = 5'd1;
        mode           = 2'd1;
        timeout_cycles = 24'd3;
    endtask

    task automatic ts(input logic [15:0] v, input logic [15:0] m,
                      input logic [7:0] link, input logic [7:0] rate,
                      input logic [7:0] l2);
        os_valid = v;
        os_match = m;
        for (int i = 0; i < 16; i++) begin
            os_link_num[8*i +: 8] = (i == 2) ? l2 : link;
            os_rate_id[8*i +: 8]  = rate;
        end
        step();
        os_valid = '0;
        os_match = '0;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        done_seen      = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        lane_mask      = '0;
        threshold      = '0;
        mode           = '0;
        timeout_cycles = '0;
        os_valid       = '0;
        os_match       = '0;
        os_link_num    = '0;
        os_rate_id     = '0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_qual", 32'(qualified_lanes), 0);
        chk("rst_link", 32'(link_num_out), 0);
        rst_n = 1'b1;
        step();

        // Four lanes, eight clean TS, unmasked lanes also strobed
        start_run(16'h000F, 5'd8, 2'd0, 24'd1000);
        chk("t1_busy", 32'(busy), 1);
        expect_run(2'b01, 16'h000F, 8'h05, 8'h11);
        d0 = done_seen;
        repeat (8) ts(16'hFFFF, 16'hFFFF, 8'h05, 8'h11, 8'h05);
        chk("t1_not_yet", 32'(done_seen), 32'(d0));
        chk("t1_qual_reg", 32'(qualified_lanes), 32'h000F);
        step();
        chk("t1_latency", 32'(done_seen), 32'(d0 + 1));
        step();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_hold_res", 32'(result), 1);

        // Lane 2 link change at count 5 restarts; sticky flag on lane 0
        start_run(16'h000F, 5'd8, 2'd0, 24'd1000);
        expect_run(2'b01, 16'h000F, 8'h05, 8'h22);
        d0 = done_seen;
        repeat (5) ts(16'h000F, 16'h000F, 8'h05, 8'h22, 8'h05);
        repeat (3) ts(16'h000F, 16'h000F, 8'h05, 8'h22, 8'h07);
        chk("t2_qual_3", 32'(qualified_lanes), 32'h000B);
        ts(16'h0005, 16'h0004, 8'h05, 8'h22, 8'h07);
        repeat (3) ts(16'h0004, 16'h0004, 8'h05, 8'h22, 8'h07);
        chk("t2_no_done", 32'(done_seen), 32'(d0));
        chk("t2_sticky", 32'(qualified_lanes), 32'h000B);
        ts(16'h0004, 16'h0004, 8'h05, 8'h22, 8'h07);
        step();
        chk("t2_done", 32'(done_seen), 32'(d0 + 1));

        // Strict majority: four of eight is not enough, five is
        start_run(16'h00FF, 5'd2, 2'd2, 24'd1000);
        expect_run(2'b01, 16'h001F, 8'h2A, 8'h03);
        d0 = done_seen;
        repeat (2) ts(16'h000F, 16'h000F, 8'h2A, 8'h03, 8'h2A);
        repeat (3) step();
        chk("t3_four", 32'(done_seen), 32'(d0));
        chk("t3_qual4", 32'(qualified_lanes), 32'h000F);
        repeat (2) ts(16'h0010, 16'h0010, 8'h2A, 8'h03, 8'h2A);
        step();
        chk("t3_five", 32'(done_seen), 32'(d0 + 1));

        // Any-lane mode with threshold 0 behaving as 1
        start_run(16'h00F0, 5'd0, 2'd1, 24'd1000);
        expect_run(2'b01, 16'h0020, 8'h33, 8'h44);
        d0 = done_seen;
        ts(16'h0020, 16'h0020, 8'h33, 8'h44, 8'h33);
        step();
        chk("t4_thr0", 32'(done_seen), 32'(d0 + 1));

        // Empty mask finishes after one RUN cycle
        start_run(16'h0000, 5'd4, 2'd0, 24'd1000);
        expect_run(2'b11, 16'h0000, 8'h00, 8'h00);
        d0 = done_seen;
        chk("t5_run", 32'(busy), 1);
        step();
        chk("t5_done", 32'(done_seen), 32'(d0 + 1));
        step();

        // Timeout with no TS traffic
        start_run(16'h0001, 5'd4, 2'd0, 24'd100);
        d0 = done_seen;
`ifdef RX_TS_QUAL_TIMEOUT_EN
        expect_run(2'b10, 16'h0000, 8'h00, 8'h00);
        repeat (99) step();
        chk("t6_early", 32'(done_seen), 32'(d0));
        step();
        chk("t6_timeout", 32'(done_seen), 32'(d0 + 1));
`else
        repeat (150) step();
        chk("t6_never", 32'(done_seen), 32'(d0));
        chk("t6_busy", 32'(busy), 1);
`endif

        // Restart mid-run clears counters and drops the aborted run
        start_run(16'h000F, 5'd8, 2'd0, 24'd1000);
        repeat (3) ts(16'h000F, 16'h000F, 8'h61, 8'h62, 8'h61);
        start_run(16'h000F, 5'd2, 2'd0, 24'd1000);
        expect_run(2'b01, 16'h000F, 8'h61, 8'h62);
        d0 = done_seen;
        chk("t7_busy", 32'(busy), 1);
        chk("t7_clr_res", 32'(result), 0);
        ts(16'h000F, 16'h000F, 8'h61, 8'h62, 8'h61);
        chk("t7_cleared", 32'(qualified_lanes), 0);
        ts(16'h000F, 16'h000F, 8'h61, 8'h62, 8'h61);
        step();
        chk("t7_done", 32'(done_seen), 32'(d0 + 1));

        // Asynchronous reset during a half-counted run
        start_run(16'h000F, 5'd2, 2'd0, 24'd1000);
        ts(16'h000F, 16'h000F, 8'h70, 8'h71, 8'h70);
        ts(16'h0003, 16'h0003, 8'h70, 8'h71, 8'h70);
        chk("t8_pre", 32'(qualified_lanes), 32'h0003);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_busy", 32'(busy), 0);
        chk("t8_qual", 32'(qualified_lanes), 0);
        chk("t8_result", 32'(result), 0);
        chk("t8_link", 32'(link_num_out), 0);
        chk("t8_rate", 32'(rate_id_out), 0);
        d0 = done_seen;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("t8_no_done", 32'(done_seen), 32'(d0));
        chk("t8_idle", 32'(busy), 0);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
